// File: rtl/lorenz_pkg.sv
// Shared constants and types for the Lorenz DDA HPS controller: register map, FSM states and
// 7.20 fixed-point parameter defaults.
package lorenz_pkg;

  localparam int unsigned DATA_W     = 27;
  localparam int unsigned NUM_PARAMS = 7;

  localparam logic [3:0] AddrCtrl    = 4'd0;
  localparam logic [3:0] AddrStatus  = 4'd1;
  localparam logic [3:0] AddrDiv     = 4'd2;
  // Parameters occupy AddrDt .. AddrDt+6 in the order dt, x0, y0, z0, sigma, beta, rho.
  localparam logic [3:0] AddrDt      = 4'd3;
  localparam logic [3:0] AddrStepCnt = 4'd10;
  localparam logic [3:0] AddrSnapX   = 4'd11;
  localparam logic [3:0] AddrSnapY   = 4'd12;
  localparam logic [3:0] AddrSnapZ   = 4'd13;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoading = 2'd1,
    StRun     = 2'd2,
    StPause   = 2'd3
  } state_e;

  localparam logic [DATA_W-1:0] DefDt    = 27'd4096;
  localparam logic [DATA_W-1:0] DefX0    = 27'h7F00000;
  localparam logic [DATA_W-1:0] DefY0    = 27'd104857;
  localparam logic [DATA_W-1:0] DefZ0    = 27'd26214400;
  localparam logic [DATA_W-1:0] DefSigma = 27'd10485760;
  localparam logic [DATA_W-1:0] DefBeta  = 27'd2796202;
  localparam logic [DATA_W-1:0] DefRho   = 27'd29360128;

  function automatic logic [DATA_W-1:0] param_default(input int unsigned idx);
    logic [DATA_W-1:0] val;
    case (idx)
      0:       val = DefDt;
      1:       val = DefX0;
      2:       val = DefY0;
      3:       val = DefZ0;
      4:       val = DefSigma;
      5:       val = DefBeta;
      6:       val = DefRho;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/step_strobe_gen.sv
// Divided step strobe: fires on the first enabled cycle after a clear, then every div_i+1 cycles.
module step_strobe_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             strobe_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (enable_i) begin
      // Divider is sampled only on reload, so a rewrite lands after the current interval.
      div_cnt_d = (div_cnt_q == '0) ? div_i : div_cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign strobe_o = enable_i && (div_cnt_q == '0);

endmodule

// File: rtl/lorenz_hps_ctrl.sv
// HPS-facing Avalon-MM controller for the Lorenz DDA: parameter shadows/actives, load/run
// sequencing, step pacing, step counting and a coherent x/y/z snapshot.
module lorenz_hps_ctrl
  import lorenz_pkg::*;
#(
  parameter int unsigned DATA_W       = lorenz_pkg::DATA_W,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned DIV_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] z_in,
  output logic              dda_reset,
  output logic              dda_en,
  output logic [DATA_W-1:0] dt_out,
  output logic [DATA_W-1:0] x0_out,
  output logic [DATA_W-1:0] y0_out,
  output logic [DATA_W-1:0] z0_out,
  output logic [DATA_W-1:0] sigma_out,
  output logic [DATA_W-1:0] beta_out,
  output logic [DATA_W-1:0] rho_out
);

  localparam int unsigned HoldW = $clog2(RESET_CYCLES + 1);

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q;
  logic              run_q;
  logic [DIV_W-1:0]  div_q;
  logic [31:0]       step_cnt_q;
  logic [DATA_W-1:0] shadow_q [NUM_PARAMS];
  logic [DATA_W-1:0] active_q [NUM_PARAMS];
  logic [DATA_W-1:0] snap_y_q, snap_z_q;
  logic [31:0]       rdata_d, rdata_q;

  logic ctrl_wr, load_req, run_eff, run_entry, strobe;
  logic unused_wdata;

  // CTRL writes act in the cycle they arrive, so run/load decisions see the incoming value.
  assign ctrl_wr      = avs_write && (avs_address == AddrCtrl);
  assign load_req     = ctrl_wr && avs_writedata[1];
  assign run_eff      = ctrl_wr ? avs_writedata[0] : run_q;
  assign run_entry    = (state_d == StRun) && (state_q != StRun);
  assign unused_wdata = ^avs_writedata[31:DATA_W];

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
    return {{(32 - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_req) state_d = StLoading;
      end
      StLoading: begin
        if (!load_req && hold_q == HoldW'(1)) state_d = run_eff ? StRun : StPause;
      end
      StRun: begin
        if (load_req)      state_d = StLoading;
        else if (!run_eff) state_d = StPause;
      end
      StPause: begin
        if (load_req)     state_d = StLoading;
        else if (run_eff) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dda_reset = 1'b0;
    dda_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        dda_reset = 1'b1;
      end
      StLoading: begin
        dda_reset = 1'b1;
        dda_en    = 1'b1;
      end
      StRun: begin
        dda_en = strobe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (load_req) begin
      hold_q <= HoldW'(RESET_CYCLES);
    end else if (state_q == StLoading && hold_q != '0) begin
      hold_q <= hold_q - HoldW'(1);
    end
  end

  step_strobe_gen #(
    .DIV_W (DIV_W)
  ) u_step_strobe_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (state_q == StRun),
    .clear_i  (run_entry),
    .div_i    (div_q),
    .strobe_o (strobe)
  );

  always_ff @(posedge clk) begin
    if (reset || load_req) begin
      step_cnt_q <= '0;
    end else if (state_q == StRun && strobe && step_cnt_q != '1) begin
      step_cnt_q <= step_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= '0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        shadow_q[i] <= param_default(i);
        active_q[i] <= param_default(i);
      end
    end else begin
      if (ctrl_wr) run_q <= avs_writedata[0];
      if (avs_write && avs_address == AddrDiv) div_q <= avs_writedata[DIV_W-1:0];
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (avs_write && avs_address == AddrDt + 4'(i)) begin
          shadow_q[i] <= avs_writedata[DATA_W-1:0];
        end
        if (load_req) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Reading X freezes Y and Z so the HPS gets a triple from a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_y_q <= '0;
      snap_z_q <= '0;
    end else if (avs_read && avs_address == AddrSnapX) begin
      snap_y_q <= y_in;
      snap_z_q <= z_in;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avs_address)
      AddrCtrl:    rdata_d = {31'd0, run_q};
      AddrStatus:  rdata_d = {30'd0, state_q};
      AddrDiv:     rdata_d = 32'(div_q);
      AddrStepCnt: rdata_d = step_cnt_q;
      AddrSnapX:   rdata_d = sext(x_in);
      AddrSnapY:   rdata_d = sext(snap_y_q);
      AddrSnapZ:   rdata_d = sext(snap_z_q);
      default: begin
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
          if (avs_address == AddrDt + 4'(i)) rdata_d = sext(shadow_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= avs_read ? rdata_d : 32'd0;
    end
  end

  assign avs_readdata = rdata_q;

  assign dt_out    = active_q[0];
  assign x0_out    = active_q[1];
  assign y0_out    = active_q[2];
  assign z0_out    = active_q[3];
  assign sigma_out = active_q[4];
  assign beta_out  = active_q[5];
  assign rho_out   = active_q[6];

endmodule

// File: tb/tb_lorenz_hps_ctrl.sv
// Self-checking bench for lorenz_hps_ctrl: directed scenarios plus randomized bus traffic
// compared against a cycle-stamped behavioural model.
module tb_lorenz_hps_ctrl;

  localparam int RESET_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [26:0] x_in, y_in, z_in;
  logic        dda_reset, dda_en;
  logic [26:0] dt_out, x0_out, y0_out, z0_out, sigma_out, beta_out, rho_out;
  logic [26:0] dut_out [7];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lorenz_hps_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .x_in          (x_in),
    .y_in          (y_in),
    .z_in          (z_in),
    .dda_reset     (dda_reset),
    .dda_en        (dda_en),
    .dt_out        (dt_out),
    .x0_out        (x0_out),
    .y0_out        (y0_out),
    .z0_out        (z0_out),
    .sigma_out     (sigma_out),
    .beta_out      (beta_out),
    .rho_out       (rho_out)
  );

  assign dut_out[0] = dt_out;
  assign dut_out[1] = x0_out;
  assign dut_out[2] = y0_out;
  assign dut_out[3] = z0_out;
  assign dut_out[4] = sigma_out;
  assign dut_out[5] = beta_out;
  assign dut_out[6] = rho_out;

  // Model: mode 0 idle, 1 loading, 2 run, 3 pause; run pulses are tracked as absolute cycle stamps.
  longint      cyc = 0;
  int          m_mode, m_load_left;
  longint      m_next_pulse;
  logic        m_run, m_rvalid;
  logic [15:0] m_div;
  logic [31:0] m_steps, m_rdata;
  logic [26:0] m_shadow [7];
  logic [26:0] m_active [7];
  logic [26:0] m_snap_y, m_snap_z;

  function automatic logic [31:0] sx(input logic [26:0] v);
    return {{5{v[26]}}, v};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_load_left = 0; m_next_pulse = 0; m_run = 0; m_rvalid = 0;
    m_div = 0; m_steps = 0; m_rdata = 0; m_snap_y = 0; m_snap_z = 0;
    m_shadow[0] = 27'd4096;     m_shadow[1] = 27'h7F00000; m_shadow[2] = 27'd104857;
    m_shadow[3] = 27'd26214400; m_shadow[4] = 27'd10485760;
    m_shadow[5] = 27'd2796202;  m_shadow[6] = 27'd29360128;
    m_active = m_shadow;
  endfunction

  function automatic logic m_dda_en();
    return (m_mode == 1) || (m_mode == 2 && cyc == m_next_pulse);
  endfunction

  function automatic logic m_dda_reset();
    return m_mode <= 1;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned a);
    case (a)
      0:  return {31'd0, m_run};
      1:  return 32'(m_mode);
      2:  return {16'd0, m_div};
      10: return m_steps;
      11: return sx(x_in);
      12: return sx(m_snap_y);
      13: return sx(m_snap_z);
      default: return (a >= 3 && a <= 9) ? sx(m_shadow[a-3]) : 32'd0;
    endcase
  endfunction

  function automatic void model_edge();
    int unsigned a;
    logic ld, run_new;
    a = avs_address;
    if (reset) begin
      model_reset();
      return;
    end
    m_rdata  = avs_read ? m_read(a) : 32'd0;
    m_rvalid = avs_read;
    if (avs_read && a == 11) begin
      m_snap_y = y_in;
      m_snap_z = z_in;
    end
    ld      = avs_write && a == 0 && avs_writedata[1];
    run_new = (avs_write && a == 0) ? avs_writedata[0] : m_run;
    if (m_mode == 2 && cyc == m_next_pulse) begin
      if (m_steps != 32'hFFFF_FFFF) m_steps = m_steps + 1;
      m_next_pulse = cyc + longint'(m_div) + 1;
    end
    if (ld) begin
      m_mode = 1; m_load_left = RESET_CYCLES; m_active = m_shadow; m_steps = 0;
    end else begin
      case (m_mode)
        1: begin
          m_load_left--;
          if (m_load_left == 0) begin
            m_mode = run_new ? 2 : 3;
            m_next_pulse = cyc + 1;
          end
        end
        2: if (!run_new) m_mode = 3;
        3: if (run_new) begin m_mode = 2; m_next_pulse = cyc + 1; end
        default: ;
      endcase
    end
    m_run = run_new;
    if (avs_write) begin
      if (a == 2) m_div = avs_writedata[15:0];
      else if (a >= 3 && a <= 9) m_shadow[a-3] = avs_writedata[26:0];
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_bus();
    avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick();
    avs_write = 0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    avs_address = a; avs_read = 1;
    tick();
    avs_read = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_bus();
    repeat (3) tick();
    reset = 0;
    n_tests++; if (dda_reset !== 1'b1) begin n_fail++; $display("FAIL reset_dda_reset: got %b want 1", dda_reset); end
    n_tests++; if (dda_en !== 1'b0) begin n_fail++; $display("FAIL reset_dda_en: got %b want 0", dda_en); end
    n_tests++; if (sigma_out !== 27'd10485760) begin n_fail++; $display("FAIL reset_sigma: got %0d want 10485760", sigma_out); end
    n_tests++; if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %0h want 0", avs_readdata); end
    bus_read(4'd1);
    n_tests++; if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %0d want 0", avs_readdata); end
    bus_read(4'd9);
    n_tests++; if (avs_readdata !== 32'd29360128) begin n_fail++; $display("FAIL reset_rho_read: got %0d want 29360128", avs_readdata); end
  endtask

  task automatic test_load_sequence();
    int k;
    bus_write(4'd9, 32'd14680064);
    n_tests++; if (rho_out !== 27'd29360128) begin n_fail++; $display("FAIL load_rho_unchanged: got %0d want 29360128", rho_out); end
    bus_write(4'd0, 32'd3);
    n_tests++; if (rho_out !== 27'd14680064) begin n_fail++; $display("FAIL load_rho_active: got %0d want 14680064", rho_out); end
    k = 0;
    while (dda_reset === 1'b1 && k < 10) begin
      n_tests++; if (dda_en !== 1'b1) begin n_fail++; $display("FAIL load_dda_en_loading: got %b want 1", dda_en); end
      k++;
      tick();
    end
    n_tests++; if (k != RESET_CYCLES) begin n_fail++; $display("FAIL load_reset_len: got %0d want %0d", k, RESET_CYCLES); end
    n_tests++; if (dda_en !== 1'b1) begin n_fail++; $display("FAIL load_first_run_pulse: got %b want 1", dda_en); end
    bus_read(4'd1);
    n_tests++; if (avs_readdata !== 32'd2) begin n_fail++; $display("FAIL load_status_run: got %0d want 2", avs_readdata); end
    bus_read(4'd0);
    n_tests++; if (avs_readdata !== 32'd1) begin n_fail++; $display("FAIL load_ctrl_read: got %0d want 1", avs_readdata); end
  endtask

  task automatic test_divider();
    int pulses;
    bus_write(4'd2, 32'd3);
    bus_write(4'd0, 32'd3);
    repeat (RESET_CYCLES) tick();
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      n_tests++;
      if (dda_en !== (i % 4 == 0)) begin
        n_fail++; $display("FAIL div_pulse cycle %0d: got %b want %b", i, dda_en, (i % 4 == 0));
      end
      if (dda_en === 1'b1) pulses++;
      tick();
    end
    n_tests++; if (pulses != 100) begin n_fail++; $display("FAIL div_pulse_count: got %0d want 100", pulses); end
    bus_read(4'd10);
    n_tests++; if (avs_readdata !== 32'd100) begin n_fail++; $display("FAIL div_step_cnt: got %0d want 100", avs_readdata); end
  endtask

  task automatic test_pause();
    logic [31:0] exp_steps;
    bus_write(4'd0, 32'd0);
    exp_steps = m_steps;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (dda_en !== 1'b0) begin n_fail++; $display("FAIL pause_dda_en %0d: got %b want 0", i, dda_en); end
      tick();
    end
    bus_read(4'd10);
    n_tests++; if (avs_readdata !== exp_steps) begin n_fail++; $display("FAIL pause_steps_a: got %0d want %0d", avs_readdata, exp_steps); end
    repeat (3) tick();
    bus_read(4'd10);
    n_tests++; if (avs_readdata !== exp_steps) begin n_fail++; $display("FAIL pause_steps_b: got %0d want %0d", avs_readdata, exp_steps); end
    bus_write(4'd0, 32'd1);
    n_tests++; if (dda_en !== 1'b1) begin n_fail++; $display("FAIL resume_first_pulse: got %b want 1", dda_en); end
    tick();
    n_tests++; if (dda_en !== 1'b0) begin n_fail++; $display("FAIL resume_gap: got %b want 0", dda_en); end
    repeat (3) tick();
    n_tests++; if (dda_en !== 1'b1) begin n_fail++; $display("FAIL resume_second_pulse: got %b want 1", dda_en); end
  endtask

  task automatic test_snapshot();
    logic [26:0] bx, by, bz, ex, ey, ez;
    bx = 27'($urandom); by = 27'($urandom); bz = 27'($urandom);
    ex = 0; ey = 0; ez = 0;
    for (int k = 0; k < 6; k++) begin
      x_in = bx + 27'(k); y_in = by + 27'(3 * k); z_in = bz - 27'(k);
      avs_read    = (k == 0 || k == 4 || k == 5);
      avs_address = (k == 0) ? 4'd11 : (k == 4) ? 4'd12 : 4'd13;
      if (k == 0) begin ex = x_in; ey = y_in; ez = z_in; end
      tick();
      if (k == 0) begin
        n_tests++; if (avs_readdata !== sx(ex)) begin n_fail++; $display("FAIL snap_x: got %0h want %0h", avs_readdata, sx(ex)); end
      end else if (k == 4) begin
        n_tests++; if (avs_readdata !== sx(ey)) begin n_fail++; $display("FAIL snap_y: got %0h want %0h", avs_readdata, sx(ey)); end
      end else if (k == 5) begin
        n_tests++; if (avs_readdata !== sx(ez)) begin n_fail++; $display("FAIL snap_z: got %0h want %0h", avs_readdata, sx(ez)); end
      end
    end
    idle_bus();
  endtask

  task automatic test_same_cycle_rw();
    logic [26:0] a_val, b_val;
    a_val = 27'($urandom) | 27'h4000000;
    b_val = 27'($urandom) & 27'h3FFFFFF;
    bus_write(4'd8, 32'(a_val));
    avs_address = 4'd8; avs_writedata = 32'(b_val); avs_read = 1; avs_write = 1;
    tick();
    idle_bus();
    n_tests++; if (avs_readdata !== sx(a_val)) begin n_fail++; $display("FAIL rw_pre_write: got %0h want %0h", avs_readdata, sx(a_val)); end
    bus_read(4'd8);
    n_tests++; if (avs_readdata !== sx(b_val)) begin n_fail++; $display("FAIL rw_post_write: got %0h want %0h", avs_readdata, sx(b_val)); end
    bus_write(4'd14, $urandom);
    bus_read(4'd14);
    n_tests++; if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_14: got %0h want 0", avs_readdata); end
    bus_read(4'd15);
    n_tests++; if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_15: got %0h want 0", avs_readdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      reset         = ($urandom_range(0, 399) == 0);
      avs_read      = (op < 30) || (op >= 90);
      avs_write     = (op >= 60);
      avs_address   = 4'($urandom_range(0, 15));
      avs_writedata = $urandom;
      if (avs_address == 4'd2) avs_writedata = $urandom_range(0, 5);
      if (avs_address == 4'd0) avs_writedata[1] = ($urandom_range(0, 7) == 0);
      x_in = 27'($urandom); y_in = 27'($urandom); z_in = 27'($urandom);
      tick();
      n_tests++; if (dda_en !== m_dda_en()) begin n_fail++; $display("FAIL rand_dda_en cyc %0d: got %b want %b", cyc, dda_en, m_dda_en()); end
      n_tests++; if (dda_reset !== m_dda_reset()) begin n_fail++; $display("FAIL rand_dda_reset cyc %0d: got %b want %b", cyc, dda_reset, m_dda_reset()); end
      if (m_rvalid) begin
        n_tests++; if (avs_readdata !== m_rdata) begin n_fail++; $display("FAIL rand_read cyc %0d: got %0h want %0h", cyc, avs_readdata, m_rdata); end
      end
      for (int i = 0; i < 7; i++) begin
        n_tests++; if (dut_out[i] !== m_active[i]) begin n_fail++; $display("FAIL rand_active%0d cyc %0d: got %0h want %0h", i, cyc, dut_out[i], m_active[i]); end
      end
    end
    reset = 0;
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid_loading();
    bus_write(4'd9, 32'd1234567);
    bus_write(4'd0, 32'd2);
    tick();
    n_tests++; if (rho_out !== 27'd1234567) begin n_fail++; $display("FAIL midload_rho_loaded: got %0d want 1234567", rho_out); end
    reset = 1;
    tick();
    reset = 0;
    n_tests++; if (dda_reset !== 1'b1) begin n_fail++; $display("FAIL midload_dda_reset: got %b want 1", dda_reset); end
    n_tests++; if (dda_en !== 1'b0) begin n_fail++; $display("FAIL midload_dda_en: got %b want 0", dda_en); end
    n_tests++; if (rho_out !== 27'd29360128) begin n_fail++; $display("FAIL midload_rho_active: got %0d want 29360128", rho_out); end
    bus_read(4'd1);
    n_tests++; if (avs_readdata !== 32'd0) begin n_fail++; $display("FAIL midload_status: got %0d want 0", avs_readdata); end
    bus_read(4'd9);
    n_tests++; if (avs_readdata !== 32'd29360128) begin n_fail++; $display("FAIL midload_rho_shadow: got %0d want 29360128", avs_readdata); end
  endtask

  initial begin
    model_reset();
    reset = 1;
    idle_bus();
    x_in = 0; y_in = 0; z_in = 0;
    test_reset();
    test_load_sequence();
    test_divider();
    test_pause();
    test_snapshot();
    test_same_cycle_rw();
    test_random();
    test_reset_mid_loading();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
